// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared encodings and sizing helper for the 64-to-256 width-converting FIFO
package sync_fifo_pkg;

  localparam int OUT_COMB = 0;
  localparam int OUT_REG  = 1;

  // One extra wrap bit so equal indices can still tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - input-word storage array with one write port and a RATIO-word wide read port
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int RATIO      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic [AW-1:0]               rd_addr_i,
  output logic [RATIO*DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Oldest word lands in the lowest lane; index arithmetic wraps in AW bits.
  for (genvar k = 0; k < RATIO; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rd_addr_i + AW'(k);
    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[idx];
  end

endmodule

// File: rtl/sync_fifo_64to256.sv
// rtl/sync_fifo_64to256.sv - single-clock FIFO packing 64-bit writes into 256-bit reads
// Optional sticky overflow/underflow outputs under SYNC_FIFO_64TO256_ERR_FLAGS_EN.
module sync_fifo_64to256
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_I = 64,
  parameter int DATA_WIDTH_O = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int OUTPUT_MODE  = OUT_COMB
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_wr,
  input  logic [DATA_WIDTH_I-1:0] fifo_din,
  output logic                    fifo_full,
  input  logic                    fifo_rd,
  output logic [DATA_WIDTH_O-1:0] fifo_dout,
`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
  output logic                    fifo_ovf,
  output logic                    fifo_udf,
`endif
  output logic                    fifo_empty
);

  localparam int RATIO = DATA_WIDTH_O / DATA_WIDTH_I;
  localparam int PW    = ptr_width(FIFO_DEPTH);
  localparam int AW    = PW - 1;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           count;
  logic                    wr_acc, rd_acc;
  logic [DATA_WIDTH_O-1:0] head_data;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == PW'(FIFO_DEPTH));
  assign fifo_empty = (count < PW'(RATIO));
  assign wr_acc     = fifo_wr && !fifo_full;
  assign rd_acc     = fifo_rd && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(RATIO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH_I),
    .DEPTH      (FIFO_DEPTH),
    .RATIO      (RATIO),
    .AW         (AW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (fifo_din),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (head_data)
  );

  if (OUTPUT_MODE == OUT_REG) begin : g_dout_reg
    logic [DATA_WIDTH_O-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= head_data;
      end
    end
    assign fifo_dout = dout_q;
  end else begin : g_dout_comb
    assign fifo_dout = head_data;
  end

`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (fifo_wr && fifo_full)  ovf_q <= 1'b1;
      if (fifo_rd && fifo_empty) udf_q <= 1'b1;
    end
  end
  assign fifo_ovf = ovf_q;
  assign fifo_udf = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_64to256.sv
// tb/tb_sync_fifo_64to256.sv - self-checking bench for both output modes against a word-queue model
module tb_sync_fifo_64to256;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_wr = 1'b0;
  logic         fifo_rd = 1'b0;
  logic [63:0]  fifo_din = '0;
  logic         full0, empty0, full1, empty1;
  logic [255:0] dout0, dout1;
`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
  logic         ovf0, udf0, ovf1, udf1;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0]  model[$];
  logic [255:0] exp_reg = '0;
  logic         exp_ovf = 1'b0;
  logic         exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_64to256 #(.OUTPUT_MODE(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_full  (full0),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (dout0),
`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
    .fifo_ovf   (ovf0),
    .fifo_udf   (udf0),
`endif
    .fifo_empty (empty0)
  );

  sync_fifo_64to256 #(.OUTPUT_MODE(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_full  (full1),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (dout1),
`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
    .fifo_ovf   (ovf1),
    .fifo_udf   (udf1),
`endif
    .fifo_empty (empty1)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] head_group();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*64 +: 64] = model[k];
    return r;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".empty0"}, 256'(empty0), 256'(model.size() < 4));
    check_eq({tag, ".full0"},  256'(full0),  256'(model.size() == 8));
    check_eq({tag, ".empty1"}, 256'(empty1), 256'(model.size() < 4));
    check_eq({tag, ".full1"},  256'(full1),  256'(model.size() == 8));
    if (model.size() >= 4) check_eq({tag, ".dout0"}, dout0, head_group());
    check_eq({tag, ".dout1"}, dout1, exp_reg);
`ifdef SYNC_FIFO_64TO256_ERR_FLAGS_EN
    check_eq({tag, ".ovf0"}, 256'(ovf0), 256'(exp_ovf));
    check_eq({tag, ".udf0"}, 256'(udf0), 256'(exp_udf));
    check_eq({tag, ".ovf1"}, 256'(ovf1), 256'(exp_ovf));
    check_eq({tag, ".udf1"}, 256'(udf1), 256'(exp_udf));
`endif
  endtask

  // Called #1 after a rising edge; drives one cycle, then updates the model and checks.
  task automatic cycle(input string tag, input logic wr, input logic [63:0] d, input logic rd);
    bit acc_wr, acc_rd;
    acc_wr = wr && (model.size() < 8);
    acc_rd = rd && (model.size() >= 4);
    if (wr && !acc_wr) exp_ovf = 1'b1;
    if (rd && !acc_rd) exp_udf = 1'b1;
    if (acc_rd) exp_reg = head_group();
    fifo_wr  = wr;
    fifo_din = d;
    fifo_rd  = rd;
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    if (acc_rd) for (int k = 0; k < 4; k++) void'(model.pop_front());
    if (acc_wr) model.push_back(d);
    check_state(tag);
  endtask

  task automatic model_reset();
    model.delete();
    exp_reg = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  initial begin
    int writes;
    int gap;
    logic w, r;

    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("reset.empty0", 256'(empty0), 256'(1));
    check_eq("reset.full0",  256'(full0),  256'(0));
    check_eq("reset.dout0",  dout0, '0);
    check_eq("reset.dout1",  dout1, '0);
    check_eq("reset.empty1", 256'(empty1), 256'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_state("idle");

    cycle("pat0", 1'b1, 64'h0, 1'b0);
    cycle("pat1", 1'b1, ONES,  1'b0);
    cycle("pat2", 1'b1, 64'h0, 1'b0);
    cycle("pat3", 1'b1, ONES,  1'b0);
    check_eq("pattern.dout0", dout0, {ONES, 64'h0, ONES, 64'h0});

    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 64'h1000 + 64'(i), 1'b0);
    check_eq("full.flag", 256'(full0), 256'(1));
    cycle("drop9", 1'b1, 64'hDEAD_BEEF, 1'b0);
    cycle("wr_rd_full", 1'b1, 64'hBAD0_BAD0, 1'b1);
    cycle("rd2", 1'b0, '0, 1'b1);
    check_eq("rd2.empty", 256'(empty0), 256'(1));
    check_eq("rd2.dout1", dout1, {64'h1003, 64'h1002, 64'h1001, 64'h1000});
    cycle("rd_empty", 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("hold", 1'b0, '0, 1'b0);

    writes = 0;
    gap = 0;
    for (int c = 0; c < 400 && (writes < 16 || model.size() >= 4); c++) begin
      w = (writes < 16) && (gap == 0) && (model.size() < 8);
      if (w) begin
        writes++;
        gap = $urandom_range(1, 3);
      end else if (gap > 0) begin
        gap--;
      end
      r = (model.size() >= 4) && ($urandom_range(0, 1) == 1);
      cycle("guarded", w, {$urandom, $urandom}, r);
    end
    check_eq("guarded.drained", 256'(model.size()), 256'(0));

    for (int c = 0; c < 300; c++) begin
      cycle("free", ($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
    end

    while (model.size() < 6) cycle("prefill", 1'b1, {$urandom, $urandom}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst.empty0", 256'(empty0), 256'(1));
    check_eq("async_rst.full0",  256'(full0),  256'(0));
    check_eq("async_rst.dout1",  dout1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("post_rst");
    cycle("post_rst_rd", 1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
